// File: rtl/reaction_session_if.sv
// Handshake bundle between the reaction-time session controller and the board:
// button/tick/LFSR inputs in, LED and display-path outputs back.
interface reaction_session_if;
    logic        start;
    logic        stop;
    logic        tick_ms;
    logic [3:0]  rnd;
    logic        led;
    logic [15:0] value;
    logic [1:0]  disp_mode;
    logic [3:0]  trial;
    logic [15:0] best;
    logic        done;

    modport master (
        output start, stop, tick_ms, rnd,
        input  led, value, disp_mode, trial, best, done
    );

    modport slave (
        input  start, stop, tick_ms, rnd,
        output led, value, disp_mode, trial, best, done
    );
endinterface

// File: rtl/reaction_session_ctrl.sv
// Multi-trial reaction-time session sequencer: random pre-delay, BCD ms timing, best tracking.
// Optional macro RT_INPUT_SYNC_EN adds two-flop synchronizers on start/stop.
module reaction_session_ctrl #(
    parameter int TRIALS        = 4,
    parameter int MIN_DELAY_MS  = 2000,
    parameter int DELAY_STEP_MS = 500,
    parameter int HOLD_MS       = 1500,
    parameter int TIMEOUT_MS    = 1000
) (
    input  logic              clk,
    input  logic              reset,
    reaction_session_if.slave bus
);

    localparam logic [15:0] TIMEOUT_BCD = {4'((TIMEOUT_MS / 1000) % 10), 4'((TIMEOUT_MS / 100) % 10),
                                           4'((TIMEOUT_MS / 10) % 10),   4'(TIMEOUT_MS % 10)};

    typedef enum logic [2:0] {IDLE, WAIT, MEASURE, SHOW, FAULT, SUMMARY} state_t;

    state_t      state;
    logic        start_in, stop_in, start_q, stop_q, start_e, stop_e;
    logic [19:0] cnt, delay, cnt_nxt, delay_new;
    logic [15:0] value_r, best_r, value_inc;
    logic [1:0]  mode_r;
    logic [3:0]  trial_r;
    logic        led_r, done_r;

`ifdef RT_INPUT_SYNC_EN
    logic [1:0] start_sync, stop_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_sync <= '0;
            stop_sync  <= '0;
        end else begin
            start_sync <= {start_sync[0], bus.start};
            stop_sync  <= {stop_sync[0], bus.stop};
        end
    end

    assign start_in = start_sync[1];
    assign stop_in  = stop_sync[1];
`else
    assign start_in = bus.start;
    assign stop_in  = bus.stop;
`endif

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
                else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign start_e   = start_in & ~start_q;
    assign stop_e    = stop_in & ~stop_q;
    assign cnt_nxt   = cnt + 20'd1;
    assign delay_new = 20'(MIN_DELAY_MS) + 20'(bus.rnd) * 20'(DELAY_STEP_MS);
    assign value_inc = bcd_inc(value_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            led_r   <= 1'b1;
            value_r <= 16'h0000;
            mode_r  <= 2'd2;
            trial_r <= 4'd0;
            best_r  <= 16'h9999;
            done_r  <= 1'b0;
            cnt     <= '0;
            delay   <= '0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            start_q <= start_in;
            stop_q  <= stop_in;
            case (state)
                IDLE: if (start_e) begin
                    trial_r <= 4'd0;
                    best_r  <= 16'h9999;
                    delay   <= delay_new;
                    cnt     <= '0;
                    mode_r  <= 2'd0;
                    state   <= WAIT;
                end
                WAIT: if (stop_e) begin
                    value_r <= 16'h9999;
                    mode_r  <= 2'd3;
                    state   <= FAULT;
                end else if (bus.tick_ms) begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == delay) begin
                        led_r   <= 1'b0;
                        value_r <= 16'h0000;
                        mode_r  <= 2'd1;
                        state   <= MEASURE;
                    end
                end
                // Stop beats a coincident tick, so a stop on the timeout tick scores TIMEOUT-1.
                MEASURE: if (stop_e) begin
                    led_r <= 1'b1;
                    cnt   <= '0;
                    if (value_r < best_r) best_r <= value_r;
                    state <= SHOW;
                end else if (bus.tick_ms) begin
                    if (value_inc == TIMEOUT_BCD) begin
                        value_r <= TIMEOUT_BCD;
                        led_r   <= 1'b1;
                        mode_r  <= 2'd3;
                        state   <= FAULT;
                    end else begin
                        value_r <= value_inc;
                    end
                end
                SHOW: if (bus.tick_ms) begin
                    cnt <= cnt_nxt;
                    if (cnt_nxt == 20'(HOLD_MS)) begin
                        if (trial_r == 4'(TRIALS - 1)) begin
                            value_r <= best_r;
                            done_r  <= 1'b1;
                            state   <= SUMMARY;
                        end else begin
                            trial_r <= trial_r + 4'd1;
                            delay   <= delay_new;
                            cnt     <= '0;
                            mode_r  <= 2'd0;
                            state   <= WAIT;
                        end
                    end
                end
                FAULT, SUMMARY: if (start_e) begin
                    mode_r <= 2'd2;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.led       = led_r;
    assign bus.value     = value_r;
    assign bus.disp_mode = mode_r;
    assign bus.trial     = trial_r;
    assign bus.best      = best_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Bench for reaction_session_ctrl: vector table, directed corner sequences,
// and randomized sessions scored against a trial-level reference model.
module tb_reaction_session_ctrl;
    localparam int T     = 2;
    localparam int MIN_D = 2;
    localparam int STEP  = 1;
    localparam int HOLD  = 3;
    localparam int TMO   = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    reaction_session_if bus();

    reaction_session_ctrl #(
        .TRIALS(T), .MIN_DELAY_MS(MIN_D), .DELAY_STEP_MS(STEP), .HOLD_MS(HOLD), .TIMEOUT_MS(TMO)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          rnd;
        int          react;     // ticks in MEASURE before stop; negative = early press
        int          exp_fall;
        logic [15:0] exp_val;
        logic [1:0]  exp_mode;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int x);
        return {4'((x / 1000) % 10), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.tick_ms = 1'b1; step();
        bus.tick_ms = 1'b0; step();
    endtask

    task automatic tick_gap();
        bus.tick_ms = 1'b1; step();
        bus.tick_ms = 1'b0;
        repeat (int'($urandom_range(1, 3))) step();
    endtask

    task automatic press_start();
        bus.start = 1'b1; step();
        bus.start = 1'b0; step();
    endtask

    task automatic press_stop();
        bus.stop = 1'b1; step();
        bus.stop = 1'b0; step();
    endtask

    task automatic stop_with_tick();
        bus.stop = 1'b1; bus.tick_ms = 1'b1; step();
        bus.stop = 1'b0; bus.tick_ms = 1'b0; step();
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.stop = 1'b0; bus.tick_ms = 1'b0;
        reset = 1'b1; step(); step();
        reset = 1'b0; step();
    endtask

    // Ticks until the LED drops; bound keeps a stuck LED from hanging the run.
    task automatic wait_fall(output int n);
        n = 0;
        while (bus.led === 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Trial-level model: fall tick = MIN + rnd*STEP, score = react ticks, best = min score.
    task automatic run_session(input int rv[T], input int rt[T], input bit swt[T]);
        int best_b;
        int n;
        best_b = 9999;
        bus.rnd = 4'(rv[0]);
        press_start();
        chk("sess_wait_mode", bus.disp_mode, 0);
        chk("sess_best_clear", bus.best, 16'h9999);
        for (int t = 0; t < T; t++) begin
            wait_fall(n);
            chk("sess_fall", n, MIN_D + rv[t] * STEP);
            repeat (rt[t]) tick_gap();
            chk("sess_count", bus.value, to_bcd(rt[t]));
            if (swt[t]) stop_with_tick();
            else press_stop();
            if (rt[t] < best_b) best_b = rt[t];
            chk("sess_show_val", bus.value, to_bcd(rt[t]));
            chk("sess_show_best", bus.best, to_bcd(best_b));
            chk("sess_show_led", bus.led, 1);
            if (t + 1 < T) bus.rnd = 4'(rv[t + 1]);
            press_stop();
            press_start();
            chk("sess_show_ignore", {14'd0, bus.disp_mode, bus.value}, {14'd1, to_bcd(rt[t])});
            repeat (HOLD) tick_gap();
            if (t + 1 < T) begin
                chk("sess_trial", bus.trial, t + 1);
                chk("sess_next_mode", bus.disp_mode, 0);
            end
        end
        chk("sess_done", bus.done, 1);
        chk("sess_summary_val", bus.value, to_bcd(best_b));
        chk("sess_summary_mode", bus.disp_mode, 1);
        press_start();
        chk("sess_idle_mode", bus.disp_mode, 2);
        chk("sess_idle_done", bus.done, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   rv[T];
        int   rt[T];
        bit   swt[T];

        vecs[0] = '{3,  12, 5,  16'h0012, 2'd1};
        vecs[1] = '{0,  45, 2,  16'h0045, 2'd1};
        vecs[2] = '{15, 9,  17, 16'h0009, 2'd1};
        vecs[3] = '{7,  100, 9, 16'h0100, 2'd1};
        vecs[4] = '{1,  -1, 0,  16'h9999, 2'd3};
        vecs[5] = '{0,  0,  2,  16'h0000, 2'd1};

        bus.start = 1'b0; bus.stop = 1'b0; bus.tick_ms = 1'b0; bus.rnd = 4'd0;
        reset = 1'b1;
        step(); step();
        chk("rst_led", bus.led, 1);
        chk("rst_mode", bus.disp_mode, 2);
        chk("rst_best", bus.best, 16'h9999);
        chk("rst_done", bus.done, 0);
        chk("rst_trial", bus.trial, 0);
        chk("rst_value", bus.value, 0);
        reset = 1'b0;
        step();

        // Level-held start, delay latched at entry, full trial, trial advance.
        bus.rnd = 4'd3;
        bus.start = 1'b1;
        repeat (5) step();
        bus.start = 1'b0;
        step();
        chk("hold_start_mode", bus.disp_mode, 0);
        bus.rnd = 4'd0;
        wait_fall(n);
        chk("hold_fall", n, 5);
        repeat (12) tick();
        press_stop();
        chk("t0_value", bus.value, 16'h0012);
        chk("t0_mode", bus.disp_mode, 1);
        tick(); tick();
        chk("t0_hold_trial", bus.trial, 0);
        tick();
        chk("t1_trial", bus.trial, 1);
        chk("t1_led", bus.led, 1);
        chk("t1_mode", bus.disp_mode, 0);

        // Early press in WAIT, ticks ignored in FAULT, best cleared on new session.
        tick();
        press_stop();
        chk("early_mode", bus.disp_mode, 3);
        chk("early_value", bus.value, 16'h9999);
        chk("early_led", bus.led, 1);
        tick(); tick();
        chk("fault_tick_value", bus.value, 16'h9999);
        press_start();
        chk("fault_to_idle", bus.disp_mode, 2);
        press_start();
        chk("new_sess_best", bus.best, 16'h9999);

        // Vector table: each entry is one trial from reset.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            bus.rnd = 4'(vecs[i].rnd);
            press_start();
            if (vecs[i].react < 0) begin
                tick();
                press_stop();
            end else begin
                wait_fall(n);
                chk($sformatf("vec%0d_fall", i), n, vecs[i].exp_fall);
                repeat (vecs[i].react) tick();
                press_stop();
                chk($sformatf("vec%0d_best", i), bus.best, vecs[i].exp_val);
            end
            chk($sformatf("vec%0d_value", i), bus.value, vecs[i].exp_val);
            chk($sformatf("vec%0d_mode", i), bus.disp_mode, vecs[i].exp_mode);
            chk($sformatf("vec%0d_led", i), bus.led, 1);
        end

        // Timeout with BCD carry checks along the way.
        do_reset();
        bus.rnd = 4'd0;
        press_start();
        tick(); tick();
        chk("tmo_led_on", bus.led, 0);
        for (int i = 1; i <= 999; i++) begin
            tick();
            if (i == 9 || i == 10 || i == 99 || i == 100 || i == 999)
                chk($sformatf("tmo_count_%0d", i), bus.value, to_bcd(i));
        end
        tick();
        chk("tmo_value", bus.value, 16'h1000);
        chk("tmo_mode", bus.disp_mode, 3);
        chk("tmo_led", bus.led, 1);
        tick();
        chk("tmo_fault_hold", bus.value, 16'h1000);
        press_start();
        chk("tmo_idle", bus.disp_mode, 2);

        // Stop on the timeout tick: stop wins, score is TIMEOUT-1.
        do_reset();
        press_start();
        tick(); tick();
        repeat (999) tick();
        stop_with_tick();
        chk("stop_tmo_value", bus.value, 16'h0999);
        chk("stop_tmo_mode", bus.disp_mode, 1);
        chk("stop_tmo_best", bus.best, 16'h0999);

        // Reset mid-MEASURE: LED released before the next clock edge.
        do_reset();
        press_start();
        tick(); tick();
        tick();
        chk("mid_led_low", bus.led, 0);
        reset = 1'b1;
        #1;
        chk("mid_rst_led", bus.led, 1);
        chk("mid_rst_mode", bus.disp_mode, 2);
        chk("mid_rst_value", bus.value, 0);
        reset = 1'b0;
        step();

        // Two-trial session: 0045 then 0038, second stop coincides with a tick.
        rv[0] = 4; rv[1] = 9;
        rt[0] = 45; rt[1] = 38;
        swt[0] = 1'b0; swt[1] = 1'b1;
        run_session(rv, rt, swt);

        for (int s = 0; s < 12; s++) begin
            for (int t = 0; t < T; t++) begin
                rv[t]  = int'($urandom_range(0, 15));
                rt[t]  = int'($urandom_range(0, 60));
                swt[t] = 1'($urandom_range(0, 1));
            end
            run_session(rv, rt, swt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
